// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core data-memory port.
// It accepts one request at a time, waits WAIT_STATES cycles, then performs a
// byte-enabled write or a full-word read on a word-organised RAM. Completion
// is signalled by a single-cycle data_rvalid_o pulse.
// Optional build macro DMEM_ERR_EN: out-of-range accesses are flagged on
// data_err_o, writes to them are dropped, and reads of them return zero.
// Without the macro, addresses alias modulo DEPTH_WORDS and data_err_o is 0.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_rvalid_o,
  output logic        data_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              latch_en;
  logic              access_en;

  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [IDX_W-1:0]  idx_q;
  logic              oor_q;

  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic              err_q;

  logic [31:0]       offset;
  logic              oor_in;
  logic              unused_offset;

  logic [31:0]       mem [DEPTH_WORDS];

  // Byte offset from the RAM base; the word index is taken from bits above [1:0].
  assign offset        = data_addr_i - BASE_ADDR;
  assign unused_offset = ^offset;

`ifdef DMEM_ERR_EN
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  assign oor_in = (data_addr_i < BASE_ADDR) || ({1'b0, offset} >= SPAN_BYTES);
`else
  assign oor_in = 1'b0;
`endif

  // Next-state logic: request acceptance, wait countdown, abort and access strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    access_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (data_req_i) begin
          latch_en = 1'b1;
          cnt_d    = WS;
          state_d  = (WS != 4'd0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (!data_req_i) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        access_en = 1'b1;
        state_d   = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and response registers; reset returns everything to idle/zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= access_en;
      err_q    <= access_en & oor_q;
      if (access_en) begin
        rdata_q <= (we_q || oor_q) ? 32'h0 : mem[idx_q];
      end
    end
  end

  // Request fields captured when a transaction is accepted; held until the next one.
  always_ff @(posedge clk_i) begin
    if (latch_en) begin
      we_q    <= data_we_i;
      be_q    <= data_be_i;
      wdata_q <= data_wdata_i;
      idx_q   <= offset[IDX_W+1:2];
      oor_q   <= oor_in;
    end
  end

  // RAM write port: byte-merged store on the edge leaving ACCESS, contents survive reset.
  always_ff @(posedge clk_i) begin
    if (access_en && we_q && !oor_q && !rst_i) begin
      for (int n = 0; n < 4; n++) begin
        if (be_q[n]) begin
          mem[idx_q][8*n +: 8] <= wdata_q[8*n +: 8];
        end
      end
    end
  end

  assign data_rdata_o  = rdata_q;
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_STATES 1, 0, 3) driven
// by directed and random transactions, checked every cycle against a
// word-array memory model and an expected-response schedule.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int          NQ    = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_r   [3];
  logic        we_r    [3];
  logic [3:0]  be_r    [3];
  logic [31:0] addr_r  [3];
  logic [31:0] wdata_r [3];
  logic [31:0] rdata_w [3];
  logic        rvalid_w[3];
  logic        err_w   [3];

  int  cyc      = 0;
  bit  rst_prev = 1'b1;
  int  checks   = 0;
  int  errors   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
    bit          pin_en;
    logic [31:0] pin;
  } exp_t;

  exp_t        expq [3][NQ];
  int          wr_ptr [3];
  int          rd_ptr [3];
  bit          zhold  [3];
  logic [31:0] mm     [3][DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
  end

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req_r[0]), .data_we_i(we_r[0]),
    .data_be_i(be_r[0]), .data_addr_i(addr_r[0]), .data_wdata_i(wdata_r[0]),
    .data_rdata_o(rdata_w[0]), .data_rvalid_o(rvalid_w[0]), .data_err_o(err_w[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req_r[1]), .data_we_i(we_r[1]),
    .data_be_i(be_r[1]), .data_addr_i(addr_r[1]), .data_wdata_i(wdata_r[1]),
    .data_rdata_o(rdata_w[1]), .data_rvalid_o(rvalid_w[1]), .data_err_o(err_w[1]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req_r[2]), .data_we_i(we_r[2]),
    .data_be_i(be_r[2]), .data_addr_i(addr_r[2]), .data_wdata_i(wdata_r[2]),
    .data_rdata_o(rdata_w[2]), .data_rvalid_o(rvalid_w[2]), .data_err_o(err_w[2]));

  function automatic int ws(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  // Memory model: returns the response word/flag and applies the write.
  function automatic void model_access(input int k, input bit we, input logic [3:0] be,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
    int unsigned idx;
    bit          in_range;
    logic [31:0] w;
    in_range = (addr < 4 * DEPTH);
    idx      = (addr / 4) % DEPTH;
    er       = 1'b0;
    rd       = 32'h0;
`ifdef DMEM_ERR_EN
    if (!in_range) begin
      er = 1'b1;
      return;
    end
`endif
    if (we) begin
      w = mm[k][idx];
      for (int n = 0; n < 4; n++) begin
        if (be[n]) w[8*n +: 8] = wd[8*n +: 8];
      end
      mm[k][idx] = w;
    end else begin
      rd = mm[k][idx];
    end
  endfunction

  function void chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endfunction

  // Per-cycle comparison of every instance against the expected schedule.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_prev) begin
        chk("rst_rvalid", k, {31'h0, rvalid_w[k]}, 32'h0);
        chk("rst_rdata", k, rdata_w[k], 32'h0);
        chk("rst_err", k, {31'h0, err_w[k]}, 32'h0);
        rd_ptr[k] = wr_ptr[k];
        zhold[k]  = 1'b1;
      end else if (rd_ptr[k] != wr_ptr[k] && expq[k][rd_ptr[k] % NQ].cyc == cyc) begin
        exp_t e;
        e = expq[k][rd_ptr[k] % NQ];
        chk("rvalid", k, {31'h0, rvalid_w[k]}, 32'h1);
        chk("rdata", k, rdata_w[k], e.data);
        chk("err", k, {31'h0, err_w[k]}, {31'h0, e.err});
        if (e.pin_en) chk("model_pin", k, e.data, e.pin);
        rd_ptr[k]++;
        zhold[k] = 1'b0;
      end else begin
        chk("rvalid_idle", k, {31'h0, rvalid_w[k]}, 32'h0);
        if (zhold[k]) chk("rdata_after_rst", k, rdata_w[k], 32'h0);
      end
    end
  end

  // One transaction. Call at a negedge; b2b means req is still high from the
  // previous response cycle, so the DUT accepts it one cycle later.
  task automatic access(input int k, input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input bit b2b, input bit keep,
                        input bit pin_en = 1'b0, input logic [31:0] pin = 32'h0);
    int          t;
    logic [31:0] rd;
    logic        er;
    t = cyc + (b2b ? 1 : 0);
    req_r[k]   = 1'b1;
    we_r[k]    = we;
    be_r[k]    = be;
    addr_r[k]  = addr;
    wdata_r[k] = wd;
    model_access(k, we, be, addr, wd, rd, er);
    expq[k][wr_ptr[k] % NQ] = '{cyc: t + ws(k) + 2, data: rd, err: er, pin_en: pin_en, pin: pin};
    wr_ptr[k]++;
    while (cyc != t + ws(k) + 2) @(negedge clk);
    if (!keep) begin
      req_r[k] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic init_words(input int k);
    for (int i = 0; i < 16; i++) access(k, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] alias_pin;
    bit          prev_keep;
    for (int k = 0; k < 3; k++) begin
      req_r[k] = 1'b0; we_r[k] = 1'b0; be_r[k] = 4'h0; addr_r[k] = 32'h0; wdata_r[k] = 32'h0;
      wr_ptr[k] = 0; rd_ptr[k] = 0; zhold[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full write, then byte-lane merge, on the WAIT_STATES=1 instance.
    access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    access(0, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, 1'b0, 1'b0);
    access(0, 1'b0, 4'h5, 32'h12, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADAAEF);

    // Address just past the RAM: flagged or aliased to word 0.
    access(0, 1'b1, 4'hF, 32'h0, 32'h12345678, 1'b0, 1'b0);
`ifdef DMEM_ERR_EN
    alias_pin = 32'h0;
`else
    alias_pin = 32'h12345678;
`endif
    access(0, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b1, alias_pin);

    // Reset asserted during the response cycle; RAM keeps its contents.
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADAAEF);
    rst = 1'b1;
    req_r[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADAAEF);

    // WAIT_STATES=0: read, read, write with req held throughout.
    init_words(1);
    access(1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 1'b0, 1'b0);
    access(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D);
    access(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D);
    access(1, 1'b1, 4'b1000, 32'h20, 32'h11000000, 1'b1, 1'b0, 1'b1, 32'h0);
    access(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11FEF00D);

    // WAIT_STATES=3: write abandoned during WAIT leaves the word untouched.
    init_words(2);
    access(2, 1'b1, 4'hF, 32'h14, 32'hA5A5_5A5A, 1'b0, 1'b0);
    req_r[2] = 1'b1; we_r[2] = 1'b1; be_r[2] = 4'hF; addr_r[2] = 32'h14; wdata_r[2] = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    req_r[2] = 1'b0;
    repeat (8) @(negedge clk);
    access(2, 1'b0, 4'hF, 32'h14, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5_5A5A);

    // Random traffic on every instance, mixing aliased addresses and back-to-back requests.
    init_words(0);
    for (int k = 0; k < 3; k++) begin
      prev_keep = 1'b0;
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        bit          keep;
        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a + 32'h1000;
        keep = (i != 39) && ($urandom_range(0, 1) == 1);
        access(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
               prev_keep, keep);
        prev_keep = keep;
      end
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
